// File: rtl/ro_pkg.sv
// ro_pkg: shared FSM states, default parameters and window-timer width helper for ro_freq_counter.
package ro_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_MEASURE, ST_DONE} state_t;
  localparam int CNT_W_D       = 16;
  localparam int WINDOW_D      = 1024;
  localparam int SETTLE_D      = 8;
  localparam int SYNC_STAGES_D = 2;
  function automatic int win_w(input int window, input int settle);
    return $clog2((window > settle ? window : settle) + 1);
  endfunction
endpackage

// File: rtl/ro_sync_edge.sv
// ro_sync_edge: multi-flop synchronizer for the asynchronous ring output plus rising-edge detector.
module ro_sync_edge import ro_pkg::*; #(
  parameter int STAGES = SYNC_STAGES_D
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise_pulse
);
  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  always_ff @(posedge clk)
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], async_in};
      r_prev <= r_sync[STAGES-1];
    end
  assign sync_out   = r_sync[STAGES-1];
  assign rise_pulse = sync_out & ~r_prev;
endmodule

// File: rtl/ro_freq_counter.sv
// ro_freq_counter: enables the ring, settles, counts synchronized rising edges over a clk window.
// Optional RO_FREQ_SAT_EN: saturating counter with ovf flag; otherwise the count wraps.
module ro_freq_counter import ro_pkg::*; #(
  parameter int CNT_W       = CNT_W_D,
  parameter int WINDOW      = WINDOW_D,
  parameter int SETTLE      = SETTLE_D,
  parameter int SYNC_STAGES = SYNC_STAGES_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             ro_enable,
  input  logic             ro_in,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
`ifdef RO_FREQ_SAT_EN
  output logic             ovf,
`endif
  input  logic             count_ready
);
  localparam int TW = win_w(WINDOW, SETTLE);
  state_t           r_state;
  logic [TW-1:0]    r_tmr;
  logic [CNT_W-1:0] r_cnt;
  logic             w_rise;
  logic             w_sync_unused;
`ifdef RO_FREQ_SAT_EN
  logic             r_ovf;
  assign ovf = r_ovf;
`endif
  ro_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .async_in  (ro_in),
    .sync_out  (w_sync_unused),
    .rise_pulse(w_rise)
  );
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= ST_IDLE;
      r_tmr   <= '0;
      r_cnt   <= '0;
`ifdef RO_FREQ_SAT_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE:
          if (start) begin
            r_state <= ST_SETTLE;
            r_tmr   <= TW'(SETTLE - 1);
          end
        ST_SETTLE: begin
          r_cnt <= '0;
`ifdef RO_FREQ_SAT_EN
          r_ovf <= 1'b0;
`endif
          r_tmr <= r_tmr - 1'b1;
          if (r_tmr == '0) begin
            r_state <= ST_MEASURE;
            r_tmr   <= TW'(WINDOW - 1);
          end
        end
        ST_MEASURE: begin
          r_tmr <= r_tmr - 1'b1;
          if (w_rise) begin
`ifdef RO_FREQ_SAT_EN
            if (&r_cnt) r_ovf <= 1'b1;
            else
`endif
            r_cnt <= r_cnt + 1'b1;
          end
          if (r_tmr == '0) r_state <= ST_DONE;
        end
        ST_DONE:
          if (count_ready) begin
            r_state <= ST_IDLE;
`ifdef RO_FREQ_SAT_EN
            r_ovf   <= 1'b0;
`endif
          end
        default: r_state <= ST_IDLE;
      endcase
    end
  assign busy        = r_state != ST_IDLE;
  assign ro_enable   = (r_state == ST_SETTLE) || (r_state == ST_MEASURE);
  assign count_valid = r_state == ST_DONE;
  assign count       = r_cnt;
endmodule

// File: tb/tb_ro_freq_counter.sv
// tb_ro_freq_counter: randomized square-wave ring stimulus against a sample-history edge-count model.
// Two instances (16-bit and 4-bit counters) see identical stimulus; RO_FREQ_SAT_EN selects ovf checks.
module tb_ro_freq_counter;
  localparam int W = 100;
  localparam int S = 8;
  localparam int N = 2;
  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, count_ready = 1'b0, ro_in = 1'b0;
  logic       busy, ro_enable, count_valid, s_busy, s_en, s_valid;
  logic [15:0] count;
  logic [3:0]  s_count;
`ifdef RO_FREQ_SAT_EN
  logic       ovf, s_ovf;
`endif
  int  passed = 0, total = 0, cyc = 0, mode = 0, per = 10, ph = 0;
  bit  hist [0:32767];

  ro_freq_counter #(.CNT_W(16), .WINDOW(W), .SETTLE(S), .SYNC_STAGES(N)) u_big (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .ro_enable(ro_enable), .ro_in(ro_in),
    .count(count), .count_valid(count_valid),
`ifdef RO_FREQ_SAT_EN
    .ovf(ovf),
`endif
    .count_ready(count_ready));
  ro_freq_counter #(.CNT_W(4), .WINDOW(W), .SETTLE(S), .SYNC_STAGES(N)) u_small (
    .clk(clk), .rst(rst), .start(start), .busy(s_busy), .ro_enable(s_en), .ro_in(ro_in),
    .count(s_count), .count_valid(s_valid),
`ifdef RO_FREQ_SAT_EN
    .ovf(s_ovf),
`endif
    .count_ready(count_ready));

  always #5 clk = ~clk;
  always @(posedge clk) begin
    hist[cyc] = ro_in;
    cyc++;
  end
  always @(negedge clk) begin
    ph++;
    ro_in = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : ((ph % per) < per / 2);
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) $display("FAIL %s got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
    else passed++;
  endtask

  // Rising edges of the ring as seen N clk samples late, over the WINDOW edges after settling.
  function automatic int model(input int k);
    int c = 0;
    for (int e = k + S + 1; e <= k + S + W; e++)
      if (hist[e-N] && !hist[e-N-1]) c++;
    return c;
  endfunction

  task automatic run_meas(input int hold, input bit spam);
    int k, m, exp_s;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 k = cyc - 1;
    for (int i = 1; i <= S + W; i++) begin
      @(negedge clk);
      start = spam && (i % 17 == 0);
      chk("ro_enable_window", ro_enable, 1);
      chk("valid_early", count_valid, 0);
    end
    @(negedge clk);
    start = spam;
    m = model(k);
`ifdef RO_FREQ_SAT_EN
    exp_s = (m > 15) ? 15 : m;
    chk("ovf_big", ovf, 0);
    chk("ovf_small", s_ovf, (m > 15) ? 1 : 0);
`else
    exp_s = m % 16;
`endif
    chk("valid_rise", count_valid, 1);
    chk("ro_enable_done", ro_enable, 0);
    chk("busy_done", busy, 1);
    chk("count", count, m);
    chk("small_valid", s_valid, 1);
    chk("small_count", s_count, exp_s);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      start = spam && (i % 3 == 0);
      chk("hold_valid", count_valid, 1);
      chk("hold_count", count, m);
    end
    @(negedge clk);
    start = 1'b0;
    count_ready = 1'b1;
    @(negedge clk);
    count_ready = 1'b0;
    chk("valid_drop", count_valid, 0);
    chk("busy_drop", busy, 0);
    chk("small_busy_drop", s_busy, 0);
    repeat (3) @(negedge clk);
    chk("no_requeue", busy, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ro_enable", ro_enable, 0);
    chk("rst_valid", count_valid, 0);
    chk("rst_count", count, 0);
    mode = 2; per = 10; ph = $urandom_range(0, 99);
    run_meas(20, 1'b1);
    mode = 0;
    run_meas(2, 1'b0);
    mode = 1;
    run_meas(0, 1'b0);
    mode = 2; per = 4;
    run_meas(1, 1'b0);
    for (int r = 0; r < 4; r++) begin
      per = $urandom_range(2, 16);
      ph = $urandom_range(0, 999);
      run_meas($urandom_range(0, 5), 1'($urandom_range(0, 1)));
    end
    per = 10;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (S + 20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_ro_enable", ro_enable, 0);
    chk("midrst_count", count, 0);
    chk("midrst_valid", count_valid, 0);
    rst = 1'b0;
    per = 7;
    run_meas(3, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ro_freq_counter.md
Name: ro_freq_counter

Overview:
Measurement stage directly downstream of the 9-stage ring oscillator in the root-of-trust entropy/PUF path. It drives the ring's enable, lets the ring settle, then counts rising edges of the ring output over a fixed window of clk cycles. It returns the count on a valid/ready handshake to the comparator/key-extraction logic. It never uses the ring output as a clock; the ring output is sampled only through a synchronizer.

Parameters:
CNT_W, 16, width of edge count.
WINDOW, 1024, measurement window length in clk cycles (>=1).
SETTLE, 8, clk cycles with ring enabled before counting starts (>=SYNC_STAGES+1).
SYNC_STAGES, 2, flop stages on ro_in before edge detection (>=2).

Ports:
clk  input  1  system clock.
rst  input  1  synchronous reset, active-high.
start  input  1  request one measurement; sampled only in IDLE.
busy  output  1  high in any state other than IDLE.
ro_enable  output  1  drives the ring oscillator enable input.
ro_in  input  1  ring oscillator output (asynchronous to clk).
count  output  CNT_W  measured edge count.
count_valid  output  1  count is valid.
count_ready  input  1  consumer accepts count.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE; busy=0, ro_enable=0, count=0, count_valid=0; synchronizer, edge-history and internal counters=0. Reset mid-operation aborts immediately, and the next cycle matches post-reset state.
- FSM states: IDLE, SETTLE, MEASURE, DONE.
- IDLE: ro_enable=0. If start=1 at edge k, go to SETTLE; the SETTLE cycles begin at k+1.
- SETTLE: ro_enable=1 for exactly SETTLE cycles. The synchronizer runs and edges are not counted. The edge counter clears to 0. Then go to MEASURE.
- MEASURE: ro_enable=1 for exactly WINDOW cycles. Each cycle in which sync_out=1 and the previous sync_out=0 increments the edge counter by 1. Then go to DONE.
- DONE: ro_enable=0 and count_valid=1. count is held stable while count_valid=1 and count_ready=0. On count_valid & count_ready, go to IDLE and deassert count_valid.
- Latency: count_valid rises at cycle k+1+SETTLE+WINDOW.
- start outside IDLE is ignored, with no queuing. start in the IDLE cycle right after a handshake is accepted.
- count_ready outside DONE is ignored.
- Arithmetic: unsigned counter of CNT_W bits. Overflow behaviour is set by the optional feature.
- Accuracy constraint: the count is exact only if the ring frequency < f_clk/2. Faster rings alias, and this is a documented integration constraint, not an error.

Optional Feature:
Macro RO_FREQ_SAT_EN.
- Defined: the counter saturates at 2^CNT_W-1. An extra output port, ovf (1 bit), is set when an increment is attempted at saturation. ovf is valid with count_valid, is held with count, and clears on the handshake or reset.
- Undefined: no ovf port; the counter wraps modulo 2^CNT_W.

Decomposition:
- Shared package ro_pkg holds: FSM state enum (IDLE/SETTLE/MEASURE/DONE), default CNT_W/WINDOW/SETTLE/SYNC_STAGES constants, and the window-counter width derived as clog2(max(WINDOW,SETTLE)+1).
- One sub-module, ro_sync_edge: SYNC_STAGES-flop synchronizer plus rising-edge detector. Inputs: clk, rst, async_in. Outputs: sync_out, rise_pulse.

Test Plan:
- Reset, then idle 10 cycles -> busy=0, ro_enable=0, count_valid=0, count=0.
- ro_in = square wave, period 10 clk, from clk-aligned model, WINDOW=100, SETTLE=8, start pulse at cycle k -> ro_enable high k+1..k+108, count_valid at k+109, count=10 (±1 by window phase, matched to reference model).
- ro_in held 0 (and separately held 1) -> count=0.
- count_ready held low 20 cycles after count_valid -> count and count_valid stable throughout. Ready pulse -> valid drops next cycle and busy=0. Start pulses during MEASURE/DONE -> ignored, with only one measurement produced.
- rst asserted mid-MEASURE -> next cycle state IDLE, ro_enable=0, count=0. New start -> fresh correct measurement.
- CNT_W=4, ro_in period 4 clk, WINDOW=100 (≈25 edges): with RO_FREQ_SAT_EN -> count=15, ovf=1. Without it -> count = model edges mod 16.
